// File: rtl/config_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// config_port_arbiter_pkg
//   Shared constants for the configuration-port arbiter:
//     - source indices (Self, BitBang, UART, JTAG)
//     - configuration word width and source count
//     - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package config_port_arbiter_pkg;

    localparam int unsigned NUM_SRC    = 4;
    localparam int unsigned CFG_WORD_W = 32;

    localparam int unsigned SRC_SELF    = 0;
    localparam int unsigned SRC_BITBANG = 1;
    localparam int unsigned SRC_UART    = 2;
    localparam int unsigned SRC_JTAG    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SWITCH  = 2'd1,
        ST_OWN     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage : config_port_arbiter_pkg

// File: rtl/config_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// config_port_arbiter_if
//   Bundle between the configuration sources and the arbiter.
//     src_active        : per-source session request (0 Self .. 3 JTAG)
//     src_data          : four packed 32-bit words, source i at [32i+31:32i]
//     src_strobe        : per-source one-cycle word valid
//     ConfigWriteData   : word forwarded to ConfigFSM
//     ConfigWriteStrobe : word valid to ConfigFSM
//     FSM_Reset         : ConfigFSM resync request
//     grant             : one-hot current owner, or zero
//     word_count        : words forwarded in the current session
//     dropped_strobe    : pulse for a strobe that was not forwarded
//   master = source side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface config_port_arbiter_if #(
    parameter int unsigned CNT_WIDTH = 16
) ();
    import config_port_arbiter_pkg::*;

    logic [NUM_SRC-1:0]            src_active;
    logic [NUM_SRC*CFG_WORD_W-1:0] src_data;
    logic [NUM_SRC-1:0]            src_strobe;

    logic [CFG_WORD_W-1:0]         ConfigWriteData;
    logic                          ConfigWriteStrobe;
    logic                          FSM_Reset;
    logic [NUM_SRC-1:0]            grant;
    logic [CNT_WIDTH-1:0]          word_count;
    logic                          dropped_strobe;

    modport master (
        output src_active, src_data, src_strobe,
        input  ConfigWriteData, ConfigWriteStrobe, FSM_Reset,
               grant, word_count, dropped_strobe
    );

    modport slave (
        input  src_active, src_data, src_strobe,
        output ConfigWriteData, ConfigWriteStrobe, FSM_Reset,
               grant, word_count, dropped_strobe
    );

endinterface : config_port_arbiter_if

// File: rtl/config_port_arbiter_prio_enc.sv
// ---------------------------------------------------------------------------
// cfg_prio_enc
//   Fixed-priority encoder: JTAG > UART > BitBang > Self.
//     req_i : 4-bit request vector, indexed by source
//     gnt_o : one-hot winner, zero when no request
// ---------------------------------------------------------------------------
module cfg_prio_enc
    import config_port_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    output logic [NUM_SRC-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (req_i[SRC_JTAG]) begin
            gnt_o[SRC_JTAG] = 1'b1;
        end else if (req_i[SRC_UART]) begin
            gnt_o[SRC_UART] = 1'b1;
        end else if (req_i[SRC_BITBANG]) begin
            gnt_o[SRC_BITBANG] = 1'b1;
        end else if (req_i[SRC_SELF]) begin
            gnt_o[SRC_SELF] = 1'b1;
        end
    end

endmodule : cfg_prio_enc

// File: rtl/config_port_arbiter.sv
// ---------------------------------------------------------------------------
// config_port_arbiter
//   Arbitrates four configuration sources onto the single ConfigFSM write
//   port. Ownership is non-preemptive: the granted source keeps the port
//   until its session request falls. Every ownership change holds
//   FSM_Reset for GAP_CYCLES cycles so ConfigFSM resynchronises before the
//   new owner's first word.
//   Ports:
//     CLK    : clock, all state on the rising edge
//     resetn : asynchronous active-low reset
//     bus    : source/ConfigFSM bundle (slave side)
//   Parameters:
//     GAP_CYCLES : FSM_Reset cycles per ownership change (1..15)
//     CNT_WIDTH  : width of word_count (must match the interface)
// ---------------------------------------------------------------------------
module config_port_arbiter
    import config_port_arbiter_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 CLK,
    input  logic                 resetn,
    config_port_arbiter_if.slave bus
);

    localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_SRC-1:0]     grant_q, grant_d;
    logic [3:0]             gap_q, gap_d;
    logic [CNT_WIDTH-1:0]   wc_q, wc_d;
    logic [CFG_WORD_W-1:0]  data_q, data_d;
    logic                   strobe_q, strobe_d;
    logic                   drop_q, drop_d;

    logic [NUM_SRC-1:0]     enc_gnt;
    logic [NUM_SRC-1:0]     fwd_mask;
    logic                   owner_active;
    logic                   fwd;
    logic [CFG_WORD_W-1:0]  owner_data;

    cfg_prio_enc u_prio_enc (
        .req_i (bus.src_active),
        .gnt_o (enc_gnt)
    );

    // Only the owner, while in OWN and still active, may forward; any other
    // strobe in the same cycle is counted as dropped.
    assign owner_active = |(bus.src_active & grant_q);
    assign fwd_mask     = (state_q == ST_OWN) ? (grant_q & bus.src_active) : '0;
    assign fwd          = |(fwd_mask & bus.src_strobe);

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
                owner_data = bus.src_data[i*CFG_WORD_W +: CFG_WORD_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gap_d    = gap_q;
        wc_d     = wc_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        drop_d   = |(bus.src_strobe & ~fwd_mask);

        case (state_q)
            ST_IDLE: begin
                if (|bus.src_active) begin
                    grant_d = enc_gnt;
                    gap_d   = GAP_INIT;
                    wc_d    = '0;
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                // The gap always runs to completion, even if the owner has
                // already gone inactive; OWN then exits on the next cycle.
                if (gap_q == 4'd0) begin
                    state_d = ST_OWN;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            ST_OWN: begin
                if (!owner_active) begin
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (fwd) begin
            data_d   = owner_data;
            strobe_d = 1'b1;
            if (wc_q != '1) begin
                wc_d = wc_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gap_q    <= '0;
            wc_q     <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gap_q    <= gap_d;
            wc_q     <= wc_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.ConfigWriteData   = data_q;
    assign bus.ConfigWriteStrobe = strobe_q;
    assign bus.FSM_Reset         = (state_q == ST_SWITCH);
    assign bus.grant             = grant_q;
    assign bus.word_count        = wc_q;
    assign bus.dropped_strobe    = drop_q;

endmodule : config_port_arbiter

// File: tb/tb_config_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_config_port_arbiter
//   Directed bench for config_port_arbiter. Two instances share stimulus:
//   one with CNT_WIDTH=16 (fully checked) and one with CNT_WIDTH=4 (used for
//   the word_count saturation case). Source i drives word {8'hC0+i, w}, so
//   the top byte of ConfigWriteData identifies which source was forwarded.
// ---------------------------------------------------------------------------
module tb_config_port_arbiter;
    import config_port_arbiter_pkg::*;

    typedef struct {
        logic [3:0]  act;
        logic [3:0]  stb;
        logic [23:0] w;
        logic [3:0]  grant;
        logic        fr;
        logic        cws;
        logic [31:0] cwd;
        logic [15:0] wc;
        logic        drop;
    } vec_t;

    logic        CLK;
    logic        resetn;
    logic [3:0]  act;
    logic [3:0]  stb;
    logic [23:0] w;

    int n_vec;
    int n_err;
    vec_t tbl[$];

    config_port_arbiter_if #(.CNT_WIDTH(16)) bus16 ();
    config_port_arbiter_if #(.CNT_WIDTH(4))  bus4 ();

    assign bus16.src_active = act;
    assign bus16.src_strobe = stb;
    assign bus16.src_data   = {8'hC3, w, 8'hC2, w, 8'hC1, w, 8'hC0, w};
    assign bus4.src_active  = act;
    assign bus4.src_strobe  = stb;
    assign bus4.src_data    = {8'hC3, w, 8'hC2, w, 8'hC1, w, 8'hC0, w};

    config_port_arbiter #(.GAP_CYCLES(2), .CNT_WIDTH(16)) dut16 (
        .CLK    (CLK),
        .resetn (resetn),
        .bus    (bus16.slave)
    );

    config_port_arbiter #(.GAP_CYCLES(2), .CNT_WIDTH(4)) dut4 (
        .CLK    (CLK),
        .resetn (resetn),
        .bus    (bus4.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic fr,
                              input logic cws, input logic [31:0] cwd,
                              input logic [15:0] wc, input logic drop);
        n_vec++;
        cmp({tag, " grant"},      32'(bus16.grant),             32'(g));
        cmp({tag, " FSM_Reset"},  32'(bus16.FSM_Reset),         32'(fr));
        cmp({tag, " CWStrobe"},   32'(bus16.ConfigWriteStrobe), 32'(cws));
        cmp({tag, " CWData"},     bus16.ConfigWriteData,        cwd);
        cmp({tag, " word_count"}, 32'(bus16.word_count),        32'(wc));
        cmp({tag, " dropped"},    32'(bus16.dropped_strobe),    32'(drop));
    endtask

    task automatic add(input logic [3:0] a, input logic [3:0] s, input logic [23:0] wd,
                       input logic [3:0] g, input logic fr, input logic cws,
                       input logic [31:0] cwd, input logic [15:0] wc, input logic drop);
        vec_t v;
        v.act = a; v.stb = s; v.w = wd; v.grant = g; v.fr = fr;
        v.cws = cws; v.cwd = cwd; v.wc = wc; v.drop = drop;
        tbl.push_back(v);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        resetn = 1'b0;
        act    = '0;
        stb    = '0;
        w      = '0;

        //   act      stb      w          grant    FR    CWS   CWD           wc     drop
        // UART-only session: 2-cycle gap, three words, release with a late strobe
        add(4'b0100, 4'b0000, 24'h0,     4'b0100, 1'b1, 1'b0, 32'h0,        16'd0, 1'b0);
        add(4'b0100, 4'b0000, 24'h0,     4'b0100, 1'b1, 1'b0, 32'h0,        16'd0, 1'b0);
        add(4'b0100, 4'b0000, 24'h0,     4'b0100, 1'b0, 1'b0, 32'h0,        16'd0, 1'b0);
        add(4'b0100, 4'b0100, 24'hAA0001, 4'b0100, 1'b0, 1'b1, 32'hC2AA0001, 16'd1, 1'b0);
        add(4'b0100, 4'b0000, 24'h0,     4'b0100, 1'b0, 1'b0, 32'hC2AA0001, 16'd1, 1'b0);
        add(4'b0100, 4'b0100, 24'hAA0002, 4'b0100, 1'b0, 1'b1, 32'hC2AA0002, 16'd2, 1'b0);
        add(4'b0100, 4'b0100, 24'hAA0003, 4'b0100, 1'b0, 1'b1, 32'hC2AA0003, 16'd3, 1'b0);
        add(4'b0000, 4'b0100, 24'hAA0004, 4'b0000, 1'b0, 1'b0, 32'hC2AA0003, 16'd3, 1'b1);
        add(4'b0000, 4'b0000, 24'h0,     4'b0000, 1'b0, 1'b0, 32'hC2AA0003, 16'd3, 1'b0);
        // JTAG and UART together: JTAG wins, UART strobes dropped, UART waits
        add(4'b1100, 4'b0000, 24'h0,     4'b1000, 1'b1, 1'b0, 32'hC2AA0003, 16'd0, 1'b0);
        add(4'b1100, 4'b0100, 24'hBB0000, 4'b1000, 1'b1, 1'b0, 32'hC2AA0003, 16'd0, 1'b1);
        add(4'b1100, 4'b0000, 24'h0,     4'b1000, 1'b0, 1'b0, 32'hC2AA0003, 16'd0, 1'b0);
        add(4'b1100, 4'b1100, 24'hBB0001, 4'b1000, 1'b0, 1'b1, 32'hC3BB0001, 16'd1, 1'b1);
        add(4'b0100, 4'b0000, 24'h0,     4'b0000, 1'b0, 1'b0, 32'hC3BB0001, 16'd1, 1'b0);
        add(4'b0100, 4'b0000, 24'h0,     4'b0000, 1'b0, 1'b0, 32'hC3BB0001, 16'd1, 1'b0);
        add(4'b0100, 4'b0000, 24'h0,     4'b0100, 1'b1, 1'b0, 32'hC3BB0001, 16'd0, 1'b0);
        add(4'b0100, 4'b0000, 24'h0,     4'b0100, 1'b1, 1'b0, 32'hC3BB0001, 16'd0, 1'b0);
        add(4'b0100, 4'b0000, 24'h0,     4'b0100, 1'b0, 1'b0, 32'hC3BB0001, 16'd0, 1'b0);
        add(4'b0000, 4'b0000, 24'h0,     4'b0000, 1'b0, 1'b0, 32'hC3BB0001, 16'd0, 1'b0);
        add(4'b0000, 4'b0000, 24'h0,     4'b0000, 1'b0, 1'b0, 32'hC3BB0001, 16'd0, 1'b0);
        // BitBang owns; JTAG arriving mid-session does not preempt
        add(4'b0010, 4'b0000, 24'h0,     4'b0010, 1'b1, 1'b0, 32'hC3BB0001, 16'd0, 1'b0);
        add(4'b0010, 4'b0000, 24'h0,     4'b0010, 1'b1, 1'b0, 32'hC3BB0001, 16'd0, 1'b0);
        add(4'b0010, 4'b0000, 24'h0,     4'b0010, 1'b0, 1'b0, 32'hC3BB0001, 16'd0, 1'b0);
        add(4'b1010, 4'b0010, 24'hCC0001, 4'b0010, 1'b0, 1'b1, 32'hC1CC0001, 16'd1, 1'b0);
        add(4'b1010, 4'b1000, 24'hCC0002, 4'b0010, 1'b0, 1'b0, 32'hC1CC0001, 16'd1, 1'b1);
        add(4'b1010, 4'b0000, 24'h0,     4'b0010, 1'b0, 1'b0, 32'hC1CC0001, 16'd1, 1'b0);
        add(4'b1000, 4'b0000, 24'h0,     4'b0000, 1'b0, 1'b0, 32'hC1CC0001, 16'd1, 1'b0);
        add(4'b1000, 4'b0000, 24'h0,     4'b0000, 1'b0, 1'b0, 32'hC1CC0001, 16'd1, 1'b0);
        add(4'b1000, 4'b0000, 24'h0,     4'b1000, 1'b1, 1'b0, 32'hC1CC0001, 16'd0, 1'b0);
        add(4'b1000, 4'b0000, 24'h0,     4'b1000, 1'b1, 1'b0, 32'hC1CC0001, 16'd0, 1'b0);
        add(4'b1000, 4'b0000, 24'h0,     4'b1000, 1'b0, 1'b0, 32'hC1CC0001, 16'd0, 1'b0);
        add(4'b0000, 4'b0000, 24'h0,     4'b0000, 1'b0, 1'b0, 32'hC1CC0001, 16'd0, 1'b0);
        add(4'b0000, 4'b0000, 24'h0,     4'b0000, 1'b0, 1'b0, 32'hC1CC0001, 16'd0, 1'b0);
        // Self: strobe during the gap is dropped, owner leaves during the gap
        add(4'b0001, 4'b0000, 24'h0,     4'b0001, 1'b1, 1'b0, 32'hC1CC0001, 16'd0, 1'b0);
        add(4'b0001, 4'b0001, 24'hDD0001, 4'b0001, 1'b1, 1'b0, 32'hC1CC0001, 16'd0, 1'b1);
        add(4'b0000, 4'b0000, 24'h0,     4'b0001, 1'b0, 1'b0, 32'hC1CC0001, 16'd0, 1'b0);
        add(4'b0000, 4'b0001, 24'hDD0002, 4'b0000, 1'b0, 1'b0, 32'hC1CC0001, 16'd0, 1'b1);
        add(4'b0000, 4'b0000, 24'h0,     4'b0000, 1'b0, 1'b0, 32'hC1CC0001, 16'd0, 1'b0);

        // Reset state
        tick();
        tick();
        check_outs("reset", 4'b0000, 1'b0, 1'b0, 32'h0, 16'd0, 1'b0);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            act = tbl[i].act;
            stb = tbl[i].stb;
            w   = tbl[i].w;
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].grant, tbl[i].fr, tbl[i].cws,
                       tbl[i].cwd, tbl[i].wc, tbl[i].drop);
        end
        stb = '0;
        act = '0;

        // Saturation: 20 UART words, 4-bit counter stops at 15
        act = 4'b0100;
        tick();
        tick();
        tick();
        for (int k = 1; k <= 20; k++) begin
            stb = 4'b0100;
            w   = 24'(k);
            tick();
            if (k == 14 || k == 15 || k == 20) begin
                n_vec++;
                cmp($sformatf("sat4 wc k=%0d", k), 32'(bus4.word_count),
                    (k < 15) ? 32'(k) : 32'd15);
                cmp($sformatf("sat16 wc k=%0d", k), 32'(bus16.word_count), 32'(k));
            end
        end
        check_outs("sat_last", 4'b0100, 1'b0, 1'b1, 32'hC2000014, 16'd20, 1'b0);
        stb = '0;
        act = '0;
        tick();
        tick();

        // Asynchronous reset in the middle of a JTAG session
        act = 4'b1000;
        tick();
        tick();
        tick();
        check_outs("rst_own", 4'b1000, 1'b0, 1'b0, 32'hC2000014, 16'd0, 1'b0);
        stb = 4'b1000;
        w   = 24'hEE0001;
        tick();
        check_outs("rst_fwd", 4'b1000, 1'b0, 1'b1, 32'hC3EE0001, 16'd1, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check_outs("rst_async", 4'b0000, 1'b0, 1'b0, 32'h0, 16'd0, 1'b0);
        n_vec++;
        cmp("rst_async dut4 wc", 32'(bus4.word_count), 32'd0);
        tick();
        #3;
        resetn = 1'b1;
        stb    = '0;
        tick();
        check_outs("rst_sw1", 4'b1000, 1'b1, 1'b0, 32'h0, 16'd0, 1'b0);
        stb = 4'b1000;
        w   = 24'hEE0002;
        tick();
        check_outs("rst_sw2", 4'b1000, 1'b1, 1'b0, 32'h0, 16'd0, 1'b1);
        stb = '0;
        tick();
        check_outs("rst_own2", 4'b1000, 1'b0, 1'b0, 32'h0, 16'd0, 1'b0);
        stb = 4'b1000;
        w   = 24'hEE0003;
        tick();
        check_outs("rst_fwd2", 4'b1000, 1'b0, 1'b1, 32'hC3EE0003, 16'd1, 1'b0);
        stb = '0;
        act = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_config_port_arbiter
